dbf_tx_ch: RTL and testbench
============================

Name: dbf_tx_ch

Overview:
- Per-channel transmit beamformer: the transmit-side counterpart of the receive DBF channel.
- Holds a per-focal-zone transmit delay LUT, loaded over the same lut_addr/lut_we style bus the receive channels use.
- On a fire trigger: waits the zone's delay, then emits a bipolar pulse burst to the pulser.
- Drives tx_en, which gates the receive coarse-delay input valid (~tx_en) on the matching receive channel.

Parameters:
- DLY_WD, 12: width of a transmit delay entry, in clk cycles.
- ADDR_WD, 7: LUT address width; 2^ADDR_WD focal zones.
- CYC_WD, 8: width of the half-period count.
- NPULSE_WD, 4: width of the burst cycle count.
- DAMP_CYC, 16: clamp duration in cycles (used only when TX_CLAMP_EN is defined).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-high (1 = reset)
- lut_addr  in  ADDR_WD  LUT write address
- lut_we  in  1  LUT write enable
- lut_din  in  DLY_WD  delay value to write
- zone_sel  in  ADDR_WD  focal zone used for the next fire
- half_per  in  CYC_WD  half-period length in cycles; 0 is treated as 1
- n_cycles  in  NPULSE_WD  number of full pulse cycles per burst
- tx_trig  in  1  fire request, sampled in IDLE only
- pulse_p  out  1  positive pulser drive
- pulse_n  out  1  negative pulser drive
- tx_en  out  1  transmit active
- busy  out  1  burst in progress
- done  out  1  one-cycle end-of-burst strobe
- pulse_clamp  out  1  present only with TX_CLAMP_EN

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; counters cleared. LUT contents are not cleared.
- LUT:
  - 2^ADDR_WD x DLY_WD entries.
  - Write: lut_din is written at lut_addr on any cycle lut_we=1, including while busy.
  - Read: registered read at zone_sel.
  - A write during a burst does not affect that burst's latched delay.
  - Write and read of the same address in the same cycle returns the old data.
- FSM states: IDLE, LOAD, DELAY, PULSE, (CLAMP), DONE.
  - IDLE: tx_trig=1 goes to LOAD. zone_sel, half_per and n_cycles are latched in this cycle.
  - LOAD: one cycle. LUT output is registered into delay counter d.
  - DELAY: if counter==0 go to PULSE, else decrement. DELAY therefore lasts d+1 cycles.
  - PULSE: 2*n_cycles half-periods of H = max(half_per,1) cycles each.
    - Polarity alternates p, n, p, n...; the first half is pulse_p.
    - pulse_p and pulse_n are never 1 in the same cycle.
    - After the last half: go to CLAMP if enabled, else DONE.
    - If latched n_cycles=0: PULSE lasts 0 cycles; DELAY exits directly to CLAMP/DONE and no pulse is driven.
  - DONE: done=1 for one cycle; busy=0, tx_en=0; next state IDLE.
- Timing: with tx_trig sampled at cycle T:
  - busy and tx_en are 1 from T+1 through the last cycle before DONE.
  - First pulse_p cycle is T+3+d.
  - DONE cycle is T+3+d+2*n_cycles*H (plus DAMP_CYC with clamp).
- tx_trig outside IDLE (including the DONE cycle) is ignored, not queued.
- Reset asserted mid-burst: outputs go to 0 the next cycle and the FSM returns to IDLE; no done is generated.
- Delay counter: unsigned, DLY_WD bits. Max delay 2^DLY_WD-1 has no wrap.
- Half-period counter: reloads at each half boundary. Half counter width is NPULSE_WD+1.
- pulse_p and pulse_n are registered outputs (glitch-free).

Optional Feature:
- Macro: TX_CLAMP_EN.
- Defined:
  - Port pulse_clamp exists.
  - After the last half-period, state CLAMP holds pulse_clamp=1 and pulse_p/pulse_n=0 for DAMP_CYC cycles.
  - tx_en and busy stay 1 through CLAMP; then DONE.
  - With n_cycles=0, CLAMP still runs.
- Not defined: no pulse_clamp port and no CLAMP state; PULSE goes straight to DONE.

Test Plan:
- Write LUT[3]=5; zone_sel=3, half_per=4, n_cycles=2; tx_trig at cycle 10 -> tx_en/busy 1 on cycles 11..33; pulse_p 1 on 18..21 and 26..29; pulse_n 1 on 22..25 and 30..33; done=1 on cycle 34 only.
- LUT[0]=0, half_per=0, n_cycles=1, trig at cycle 0 -> pulse_p at cycle 3, pulse_n at cycle 4, done at cycle 5.
- n_cycles=0, LUT entry 2, trig at cycle 0 -> pulse_p/pulse_n stay 0; done at cycle 5 (3+d); tx_en 1 on cycles 1..4.
- Mid-burst: repeat trig on every cycle -> ignored, single done. lut_we rewrites the active zone to 100 during DELAY -> current burst timing unchanged, next burst uses 100.
- rst_n=1 during PULSE -> next cycle all outputs 0 and FSM in IDLE; no done. LUT[3] still reads 5 on the next fire.
- TX_CLAMP_EN defined, DAMP_CYC=16, scenario 1 -> pulse_clamp 1 on cycles 34..49; done at 50; tx_en 1 on 11..49.

Source files
------------

// File: rtl/dbf_tx_ch.sv
// dbf_tx_ch -- per-channel transmit beamformer.
//
// Holds a per-focal-zone transmit delay LUT. On a fire trigger it waits the
// selected zone's delay, then drives a bipolar pulse burst to the pulser.
// tx_en marks the transmit window so the paired receive channel can gate its
// coarse-delay input valid with ~tx_en.
//
// Optional feature macro: TX_CLAMP_EN -- adds a CLAMP state of DAMP_CYC
// cycles after the burst and the pulse_clamp output.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous reset, active-high (1 = reset)
//   lut_addr    LUT write address
//   lut_we      LUT write enable (honoured in any state)
//   lut_din     delay value to write, in clk cycles
//   zone_sel    focal zone used for the next fire
//   half_per    half-period length in cycles (0 behaves as 1)
//   n_cycles    full pulse cycles per burst
//   tx_trig     fire request, accepted in IDLE only
//   pulse_p     positive pulser drive (registered)
//   pulse_n     negative pulser drive (registered)
//   tx_en       transmit active
//   busy        burst in progress
//   done        one-cycle end-of-burst strobe
//   pulse_clamp clamp drive (TX_CLAMP_EN builds only)
module dbf_tx_ch #(
  parameter int DLY_WD    = 12,
  parameter int ADDR_WD   = 7,
  parameter int CYC_WD    = 8,
  parameter int NPULSE_WD = 4,
  parameter int DAMP_CYC  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_WD-1:0]   lut_addr,
  input  logic                 lut_we,
  input  logic [DLY_WD-1:0]    lut_din,
  input  logic [ADDR_WD-1:0]   zone_sel,
  input  logic [CYC_WD-1:0]    half_per,
  input  logic [NPULSE_WD-1:0] n_cycles,
  input  logic                 tx_trig,
  output logic                 pulse_p,
  output logic                 pulse_n,
  output logic                 tx_en,
  output logic                 busy,
  output logic                 done
`ifdef TX_CLAMP_EN
  ,
  output logic                 pulse_clamp
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DELAY,
    S_PULSE,
`ifdef TX_CLAMP_EN
    S_CLAMP,
`endif
    S_DONE
  } state_t;

  localparam int HALF_WD = NPULSE_WD + 1;

  logic [DLY_WD-1:0] lut_mem [2**ADDR_WD];
  logic [DLY_WD-1:0] lut_q;

  state_t               state, state_n;
  logic [DLY_WD-1:0]    dcnt, dcnt_n;
  logic [CYC_WD-1:0]    hcnt, hcnt_n;
  logic [HALF_WD-1:0]   halves, halves_n;
  logic                 phase, phase_n;
  logic [CYC_WD-1:0]    h_q, h_q_n;
  logic [NPULSE_WD-1:0] n_q, n_q_n;

`ifdef TX_CLAMP_EN
  localparam int DAMP_WD = (DAMP_CYC > 1) ? $clog2(DAMP_CYC) : 1;
  logic [DAMP_WD-1:0] damp, damp_n;
  localparam state_t S_AFTER = S_CLAMP;
`else
  localparam state_t S_AFTER = S_DONE;
`endif

  // LUT: no reset; the registered read returns pre-write data on a
  // same-address collision because both use the same edge.
  always_ff @(posedge clk) begin
    if (lut_we) lut_mem[lut_addr] <= lut_din;
    lut_q <= lut_mem[zone_sel];
  end

  always_comb begin
    state_n  = state;
    dcnt_n   = dcnt;
    hcnt_n   = hcnt;
    halves_n = halves;
    phase_n  = phase;
    h_q_n    = h_q;
    n_q_n    = n_q;
`ifdef TX_CLAMP_EN
    damp_n   = damp;
`endif
    unique case (state)
      S_IDLE: begin
        if (tx_trig) begin
          state_n = S_LOAD;
          h_q_n   = (half_per == '0) ? CYC_WD'(1) : half_per;
          n_q_n   = n_cycles;
        end
      end
      S_LOAD: begin
        dcnt_n  = lut_q;
        state_n = S_DELAY;
      end
      S_DELAY: begin
        if (dcnt == '0) begin
          if (n_q == '0) begin
            state_n = S_AFTER;
          end else begin
            state_n  = S_PULSE;
            hcnt_n   = h_q - CYC_WD'(1);
            // halves still to run after the one starting now
            halves_n = {n_q, 1'b0} - HALF_WD'(1);
            phase_n  = 1'b0;
          end
`ifdef TX_CLAMP_EN
          damp_n = DAMP_WD'(DAMP_CYC - 1);
`endif
        end else begin
          dcnt_n = dcnt - DLY_WD'(1);
        end
      end
      S_PULSE: begin
        if (hcnt == '0) begin
          if (halves == '0) begin
            state_n = S_AFTER;
          end else begin
            hcnt_n   = h_q - CYC_WD'(1);
            halves_n = halves - HALF_WD'(1);
            phase_n  = ~phase;
          end
        end else begin
          hcnt_n = hcnt - CYC_WD'(1);
        end
      end
`ifdef TX_CLAMP_EN
      S_CLAMP: begin
        if (damp == '0) state_n = S_DONE;
        else            damp_n  = damp - DAMP_WD'(1);
      end
`endif
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each output
  // is a flop that lines up exactly with the state it describes.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state   <= S_IDLE;
      dcnt    <= '0;
      hcnt    <= '0;
      halves  <= '0;
      phase   <= 1'b0;
      h_q     <= '0;
      n_q     <= '0;
      pulse_p <= 1'b0;
      pulse_n <= 1'b0;
      tx_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef TX_CLAMP_EN
      damp        <= '0;
      pulse_clamp <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      dcnt    <= dcnt_n;
      hcnt    <= hcnt_n;
      halves  <= halves_n;
      phase   <= phase_n;
      h_q     <= h_q_n;
      n_q     <= n_q_n;
      pulse_p <= (state_n == S_PULSE) && !phase_n;
      pulse_n <= (state_n == S_PULSE) &&  phase_n;
      tx_en   <= (state_n != S_IDLE) && (state_n != S_DONE);
      busy    <= (state_n != S_IDLE) && (state_n != S_DONE);
      done    <= (state_n == S_DONE);
`ifdef TX_CLAMP_EN
      damp        <= damp_n;
      pulse_clamp <= (state_n == S_CLAMP);
`endif
    end
  end

endmodule

// File: tb/tb_dbf_tx_ch.sv
// Self-checking bench for dbf_tx_ch. Expected waveforms are derived from the
// burst timing rules: trig at cycle 0, pulses start at 3+d, each half lasts
// max(half_per,1) cycles, done follows the burst (and clamp window if built).
module tb_dbf_tx_ch;
  localparam int DLY_WD = 12, ADDR_WD = 7, CYC_WD = 8, NPULSE_WD = 4;
`ifdef TX_CLAMP_EN
  localparam int DAMP = 16;
`else
  localparam int DAMP = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [ADDR_WD-1:0]   lut_addr = '0;
  logic                 lut_we = 1'b0;
  logic [DLY_WD-1:0]    lut_din = '0;
  logic [ADDR_WD-1:0]   zone_sel = '0;
  logic [CYC_WD-1:0]    half_per = '0;
  logic [NPULSE_WD-1:0] n_cycles = '0;
  logic                 tx_trig = 1'b0;
  logic                 pulse_p, pulse_n, tx_en, busy, done;
  logic                 clamp_obs;

  int total = 0;
  int bad = 0;
  int mem_m [2**ADDR_WD];

  dbf_tx_ch #(.DLY_WD(DLY_WD), .ADDR_WD(ADDR_WD), .CYC_WD(CYC_WD),
              .NPULSE_WD(NPULSE_WD), .DAMP_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .lut_addr(lut_addr), .lut_we(lut_we),
    .lut_din(lut_din), .zone_sel(zone_sel), .half_per(half_per),
    .n_cycles(n_cycles), .tx_trig(tx_trig), .pulse_p(pulse_p),
    .pulse_n(pulse_n), .tx_en(tx_en), .busy(busy), .done(done)
`ifdef TX_CLAMP_EN
    , .pulse_clamp(clamp_obs)
`endif
  );
`ifndef TX_CLAMP_EN
  assign clamp_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare {pulse_p,pulse_n,tx_en,busy,done,clamp} against expectation.
  task automatic check(input string tag, input int k, input logic [5:0] exp_v);
    logic [5:0] obs;
    obs = {pulse_p, pulse_n, tx_en, busy, done, clamp_obs};
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp_v);
    end
  endtask

  task automatic lut_write(input int a, input int v);
    lut_addr = ADDR_WD'(a);
    lut_din  = DLY_WD'(v);
    lut_we   = 1'b1;
    tick();
    lut_we   = 1'b0;
    mem_m[a] = v;
  endtask

  // wr: 0 none, 1 rewrite zone to 100 during DELAY, 2 rewrite in trig cycle.
  // abort_at: cycle at which reset is pulsed (0 = never).
  task automatic run_burst(input string tag, input int zone, input int hp,
                           input int nc, input bit spam, input int wr,
                           input int abort_at);
    int d, h, ps, pe, dn;
    logic ep, en, eb, ec;
    d  = mem_m[zone];
    h  = (hp == 0) ? 1 : hp;
    ps = 3 + d;
    pe = ps + 2 * nc * h;
    dn = pe + DAMP;
    zone_sel = ADDR_WD'(zone);
    half_per = CYC_WD'(hp);
    n_cycles = NPULSE_WD'(nc);
    tx_trig  = 1'b1;
    if (wr == 2) begin
      lut_addr = ADDR_WD'(zone); lut_din = DLY_WD'(100); lut_we = 1'b1;
    end
    tick();
    lut_we = 1'b0;
    if (wr == 2) mem_m[zone] = 100;
    for (int k = 1; k <= dn; k++) begin
      tx_trig = spam && (k < dn || k == dn);
      if (spam) begin
        zone_sel = ADDR_WD'($urandom);
        half_per = CYC_WD'($urandom_range(0, 9));
        n_cycles = NPULSE_WD'($urandom_range(0, 7));
      end
      if (wr == 1 && k == 2) begin
        lut_addr = ADDR_WD'(zone); lut_din = DLY_WD'(100); lut_we = 1'b1;
      end else begin
        lut_we = 1'b0;
      end
      if (wr == 1 && k == 3) mem_m[zone] = 100;
      if (abort_at != 0 && k == abort_at) begin
        rst_n = 1'b1;
        tx_trig = 1'b0;
        tick();
        check({tag, "_rst"}, k + 1, 6'b0);
        rst_n = 1'b0;
        for (int j = 0; j < 6; j++) begin
          tick();
          check({tag, "_post_rst"}, k + 2 + j, 6'b0);
        end
        return;
      end
      ep = (k >= ps) && (k < pe) && (((k - ps) / h) % 2 == 0);
      en = (k >= ps) && (k < pe) && (((k - ps) / h) % 2 == 1);
      eb = (k < dn);
      ec = (DAMP != 0) && (k >= pe) && (k < dn);
      check(tag, k, {ep, en, eb, eb, (k == dn), ec});
      if (k < dn) tick();
    end
    tx_trig = 1'b0;
    lut_we  = 1'b0;
    tick();
    check({tag, "_idle"}, dn + 1, 6'b0);
    tick();
    check({tag, "_idle2"}, dn + 2, 6'b0);
  endtask

  initial begin
    int z, hp, nc;
    rst_n = 1'b1;
    tick(); tick();
    check("reset", 0, 6'b0);
    rst_n = 1'b0;
    tick();
    check("reset_release", 0, 6'b0);

    for (int a = 0; a < 2**ADDR_WD; a++) lut_write(a, int'($urandom_range(0, 20)));
    lut_write(3, 5);
    lut_write(0, 0);
    lut_write(2, 2);

    run_burst("scn1", 3, 4, 2, 1'b0, 0, 0);
    run_burst("min_half", 0, 0, 1, 1'b0, 0, 0);
    run_burst("zero_cyc", 2, 3, 0, 1'b0, 0, 0);
    run_burst("spam_wr", 3, 4, 2, 1'b1, 1, 0);
    run_burst("after_wr", 3, 4, 2, 1'b0, 0, 0);
    lut_write(3, 5);
    run_burst("same_cyc_wr", 3, 2, 1, 1'b0, 2, 0);
    run_burst("new_val", 3, 1, 1, 1'b0, 0, 0);
    lut_write(3, 5);
    run_burst("abort", 3, 4, 2, 1'b0, 0, 9);
    run_burst("post_abort", 3, 4, 2, 1'b0, 0, 0);
    lut_write(7, 4095);
    run_burst("max_dly", 7, 1, 1, 1'b0, 0, 0);
    run_burst("max_cyc", 0, 1, 15, 1'b0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      z  = int'($urandom_range(0, 2**ADDR_WD - 1));
      if (z == 7) z = 8;
      hp = int'($urandom_range(0, 5));
      nc = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        lut_write(z, int'($urandom_range(0, 20)));
      run_burst("rand", z, hp, nc, 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
